// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and state type for the fetch stage of the 16-bit core
package fetch_stage_pkg;
    localparam int          DW_DEF       = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [3:0]  HLT_OP       = 4'hF;
    localparam logic [15:0] NOP          = 16'h0000;
    typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: enabled IF/ID pipeline register that can insert a bubble
import fetch_stage_pkg::*;

module if_id_reg #(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_bubble,
    input  logic [DW-1:0] i_instr,
    input  logic [DW-1:0] i_pc_plus2,
    output logic [DW-1:0] o_instr,
    output logic [DW-1:0] o_pc_plus2,
    output logic          o_valid
);
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_pc_plus2;
    logic          r_valid;

    // bubble keeps pc_plus2 so a flushed slot never samples imem_data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else if (i_en) begin
            if (i_bubble) begin
                r_instr <= NOP;
                r_valid <= 1'b0;
            end else begin
                r_instr    <= i_instr;
                r_pc_plus2 <= i_pc_plus2;
                r_valid    <= 1'b1;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus2 = r_pc_plus2;
    assign o_valid    = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, HLT stop logic and IF/ID latch for the pipelined core
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter int          DW       = DW_DEF,
    parameter logic [DW-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_write,
    input  logic          if_id_write,
    input  logic          flush,
    input  logic [DW-1:0] branch_target,
    output logic [DW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] if_id_instr,
    output logic [DW-1:0] if_id_pc_plus2,
    output logic          if_id_valid,
    output logic          halted
);
    logic [DW-1:0] r_pc;
    fetch_state_e  r_state;
    logic [DW-1:0] w_pc_plus2;
    logic          w_halted;
    logic          w_flush_q;
    logic          w_fetch_hlt;

    assign w_pc_plus2  = r_pc + DW'(2);
    assign w_halted    = (r_state == HALTED);
    assign w_flush_q   = flush & pc_write & if_id_write;
    assign w_fetch_hlt = (imem_data[DW-1 -: 4] == HLT_OP) & ~w_halted;

    // PC advance / redirect and the FETCH <-> HALTED state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= FETCH;
        end else if (pc_write) begin
            if (w_flush_q) begin
                r_pc    <= branch_target;
                r_state <= FETCH;
            end else if (!w_halted) begin
                if (w_fetch_hlt) r_state <= HALTED;
                else r_pc <= w_pc_plus2;
            end
        end
    end

    if_id_reg #(.DW(DW)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_en       (if_id_write),
        .i_bubble   (w_flush_q | w_halted),
        .i_instr    (imem_data),
        .i_pc_plus2 (w_pc_plus2),
        .o_instr    (if_id_instr),
        .o_pc_plus2 (if_id_pc_plus2),
        .o_valid    (if_id_valid)
    );

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign halted    = w_halted;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized checks of fetch_stage against a rule-level model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b1;
    logic        if_id_write = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] branch_target = 16'h0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    logic [15:0] mem [0:65535];

    logic [15:0] m_pc;
    logic        m_halted;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage #(.DW(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic pw, input logic iw, input logic fl, input logic [15:0] tgt);
        logic        fq;
        logic [15:0] word;
        rst = r; pc_write = pw; if_id_write = iw; flush = fl; branch_target = tgt;
        word = mem[m_pc];
        fq = fl & pw & iw;
        if (r) begin
            m_pc = 16'h0000; m_halted = 1'b0; m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
        end else begin
            if (iw) begin
                if (fq || m_halted) begin
                    m_instr = 16'h0000; m_valid = 1'b0;
                end else begin
                    m_instr = word; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
                end
            end
            if (pw) begin
                if (fq) begin
                    m_pc = tgt; m_halted = 1'b0;
                end else if (!m_halted) begin
                    if (word[15:12] == 4'hF) m_halted = 1'b1;
                    else m_pc = m_pc + 16'd2;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr", if_id_instr, m_instr);
        chk("pc_plus2", if_id_pc_plus2, m_pp2);
        chk("valid", {15'b0, if_id_valid}, {15'b0, m_valid});
        chk("halted", {15'b0, halted}, {15'b0, m_halted});
    endtask

    initial begin
        m_pc = 16'h0; m_halted = 1'b0; m_instr = 16'h0; m_pp2 = 16'h0; m_valid = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1234;
        step(1, 1, 1, 0, 16'h0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", {15'b0, if_id_valid}, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        chk("run_pp2_first", if_id_pc_plus2, 16'h0002);
        chk("run_valid_first", {15'b0, if_id_valid}, 16'h1);
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        chk("run_pc6", pc, 16'h0006);
        chk("run_instr", if_id_instr, 16'h1234);
        step(0, 1, 1, 0, 16'h0);
        chk("pre_stall_pc", pc, 16'h0008);
        step(0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 16'h0);
        chk("stall_pc", pc, 16'h0008);
        chk("stall_pp2", if_id_pc_plus2, 16'h0008);
        step(0, 1, 1, 0, 16'h0);
        chk("resume_pc", pc, 16'h000A);
        step(0, 1, 1, 1, 16'h0040);
        chk("br_pc", pc, 16'h0040);
        chk("br_instr", if_id_instr, 16'h0000);
        chk("br_valid", {15'b0, if_id_valid}, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        chk("br_pp2", if_id_pc_plus2, 16'h0042);
        step(0, 1, 1, 1, 16'h000C);
        step(0, 0, 0, 1, 16'h0080);
        chk("stall_flush_pc", pc, 16'h000C);
        mem[16'h0010] = 16'hF000;
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        chk("pre_hlt_pc", pc, 16'h0010);
        step(0, 1, 1, 0, 16'h0);
        chk("hlt_instr", if_id_instr, 16'hF000);
        chk("hlt_halted", {15'b0, halted}, 16'h1);
        chk("hlt_pc", pc, 16'h0010);
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        chk("halted_valid", {15'b0, if_id_valid}, 16'h0);
        chk("halted_pc", pc, 16'h0010);
        step(0, 1, 1, 1, 16'h0020);
        chk("unhalt", {15'b0, halted}, 16'h0);
        chk("unhalt_pc", pc, 16'h0020);
        step(0, 1, 1, 1, 16'hFFFE);
        step(0, 1, 1, 0, 16'h0);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_pp2", if_id_pc_plus2, 16'h0000);
        mem[16'h0000] = 16'hF123;
        step(0, 1, 1, 0, 16'h0);
        chk("halt_at0", {15'b0, halted}, 16'h1);
        step(1, 1, 1, 0, 16'h0);
        chk("rst_halt_clear", {15'b0, halted}, 16'h0);
        chk("rst_halt_valid", {15'b0, if_id_valid}, 16'h0);
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) == 0,
                 16'($urandom) & 16'hFFFE);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
